// File: rtl/pll_dyn_pkg.sv
// Shared types for the PLL dynamic-reconfiguration sequencer.
// - state_e     : sequencer FSM states
// - entry_t     : one unpacked mode-table entry
// - *Lsb / *W   : bit offsets and widths of each field in a raw 25-bit entry
// - unpack_entry: splits a raw entry into its select fields
package pll_dyn_pkg;

  localparam int unsigned EntryW    = 25;
  localparam int unsigned IcpselLsb = 0;
  localparam int unsigned LpfresLsb = 6;
  localparam int unsigned LpfcapLsb = 9;
  localparam int unsigned MdselLsb  = 11;
  localparam int unsigned Odsel0Lsb = 18;

  typedef enum logic [2:0] {
    StHold,
    StWaitLock,
    StStable,
    StLocked,
    StFault
  } state_e;

  typedef struct packed {
    logic [6:0] odsel0;
    logic [6:0] mdsel;
    logic [1:0] lpfcap;
    logic [2:0] lpfres;
    logic [5:0] icpsel;
  } entry_t;

  function automatic entry_t unpack_entry(input logic [EntryW-1:0] raw);
    entry_t e;
    e.icpsel = raw[IcpselLsb +: 6];
    e.lpfres = raw[LpfresLsb +: 3];
    e.lpfcap = raw[LpfcapLsb +: 2];
    e.mdsel  = raw[MdselLsb  +: 7];
    e.odsel0 = raw[Odsel0Lsb +: 7];
    return e;
  endfunction

endpackage

// File: rtl/pll_dyn_ctrl_if.sv
// Bus between the PLL sequencer and its surroundings.
// - mode_sel/mode_req : mode change request (from consumer logic)
// - pll_lock          : raw PLL lock (from the PLL primitive)
// - pll_reset, icpsel, lpfres, lpfcap, mdsel, odsel0 : PLL controls
// - cur_mode, locked, busy, fault, req_err          : status
// Modport slave is the sequencer; master is the consumer/PLL side.
interface pll_dyn_ctrl_if #(
  parameter int unsigned MODE_W = 2
);
  logic [MODE_W-1:0] mode_sel;
  logic              mode_req;
  logic              pll_lock;
  logic              pll_reset;
  logic [5:0]        icpsel;
  logic [2:0]        lpfres;
  logic [1:0]        lpfcap;
  logic [6:0]        mdsel;
  logic [6:0]        odsel0;
  logic [MODE_W-1:0] cur_mode;
  logic              locked;
  logic              busy;
  logic              fault;
  logic              req_err;

  modport master (
    output mode_sel, mode_req, pll_lock,
    input  pll_reset, icpsel, lpfres, lpfcap, mdsel, odsel0,
    input  cur_mode, locked, busy, fault, req_err
  );

  modport slave (
    input  mode_sel, mode_req, pll_lock,
    output pll_reset, icpsel, lpfres, lpfcap, mdsel, odsel0,
    output cur_mode, locked, busy, fault, req_err
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// - clk, reset : destination clock, synchronous active-high reset
// - d          : asynchronous input
// - q          : synchronised output (2 cycles latency)
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL dynamic-reconfiguration sequencer. Applies one of NMODES table entries to the
// PLL with a reset/settle/lock sequence, supervises lock and retries on failure.
// - clk, reset : reference clock, synchronous active-high reset
// - bus        : request inputs, raw lock input, PLL controls and status (slave side)
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int unsigned              NMODES        = 4,
  parameter int unsigned              MODE_W        = (NMODES > 1) ? $clog2(NMODES) : 1,
  parameter logic [NMODES*EntryW-1:0] MODE_TABLE    = '0,
  parameter int unsigned              RST_CYCLES    = 16,
  parameter int unsigned              SETTLE_CYCLES = 8,
  parameter int unsigned              LOCK_TIMEOUT  = 65536,
  parameter int unsigned              LOCK_STABLE   = 1024,
  parameter int unsigned              MAX_RETRY     = 3
) (
  input logic              clk,
  input logic              reset,
  pll_dyn_ctrl_if.slave    bus
);

  localparam int unsigned CntMax = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned TmoW   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  localparam logic [CntW-1:0]   RstLoad    = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0]   StableLoad = CntW'(LOCK_STABLE - 1);
  localparam logic [TmoW-1:0]   TmoLast    = TmoW'(LOCK_TIMEOUT - 1);
  localparam logic [RetryW-1:0] RetryMax   = RetryW'(MAX_RETRY);

  // Selects must be settled for SETTLE_CYCLES inside the reset hold.
  if (RST_CYCLES < SETTLE_CYCLES || RST_CYCLES < 1 || LOCK_STABLE < 1 ||
      LOCK_TIMEOUT < 1 || MAX_RETRY < 1 || NMODES < 1) begin : g_bad_params
    $error("pll_dyn_ctrl: illegal parameters (need RST_CYCLES >= SETTLE_CYCLES, all >= 1)");
  end

  function automatic entry_t entry_at(input logic [MODE_W-1:0] m);
    entry_t e;
    e = unpack_entry(MODE_TABLE[EntryW-1:0]);
    for (int unsigned i = 0; i < NMODES; i++) begin
      if (m == MODE_W'(i)) e = unpack_entry(MODE_TABLE[EntryW*i +: EntryW]);
    end
    return e;
  endfunction

  state_e            state_q;
  entry_t            sel_q;
  logic [MODE_W-1:0] cur_mode_q;
  logic [CntW-1:0]   cnt_q;
  logic [TmoW-1:0]   tmo_q;
  logic [RetryW-1:0] retry_q;
  logic              pll_reset_q, locked_q, busy_q, fault_q, req_err_q;

  logic              lock_s;
  logic              sel_in_range, req_take, tmo_exp, attempt_fail;
  logic [RetryW-1:0] retry_inc;

  sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.pll_lock),
    .q     (lock_s)
  );

  assign sel_in_range = 32'(bus.mode_sel) < NMODES;
  // Re-requesting the mode that is already locked must not disturb the clock.
  assign req_take     = bus.mode_req && sel_in_range &&
                        !(state_q == StLocked && bus.mode_sel == cur_mode_q);
  assign tmo_exp      = tmo_q >= TmoLast;
  assign attempt_fail = !lock_s && ((state_q == StLocked) ||
                        ((state_q == StWaitLock || state_q == StStable) && tmo_exp));
  assign retry_inc    = retry_q + RetryW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHold;
      sel_q       <= unpack_entry(MODE_TABLE[EntryW-1:0]);
      cur_mode_q  <= '0;
      cnt_q       <= RstLoad;
      tmo_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
      fault_q     <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      req_err_q <= bus.mode_req && !sel_in_range;
      if (req_take) begin
        // A request overrides any simultaneous lock loss or timeout.
        state_q     <= StHold;
        cur_mode_q  <= bus.mode_sel;
        sel_q       <= entry_at(bus.mode_sel);
        cnt_q       <= RstLoad;
        tmo_q       <= '0;
        retry_q     <= '0;
        pll_reset_q <= 1'b1;
        locked_q    <= 1'b0;
        busy_q      <= 1'b1;
        fault_q     <= 1'b0;
      end else if (attempt_fail) begin
        retry_q     <= retry_inc;
        pll_reset_q <= 1'b1;
        locked_q    <= 1'b0;
        if (retry_inc == RetryMax) begin
          state_q <= StFault;
          busy_q  <= 1'b0;
          fault_q <= 1'b1;
        end else begin
          state_q <= StHold;
          sel_q   <= entry_at(cur_mode_q);
          cnt_q   <= RstLoad;
          tmo_q   <= '0;
          busy_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          StHold: begin
            if (cnt_q == '0) begin
              state_q     <= StWaitLock;
              pll_reset_q <= 1'b0;
              tmo_q       <= '0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StWaitLock: begin
            if (!tmo_exp) tmo_q <= tmo_q + 1'b1;
            if (lock_s) begin
              state_q <= StStable;
              cnt_q   <= StableLoad;
            end
          end
          StStable: begin
            if (!tmo_exp) tmo_q <= tmo_q + 1'b1;
            if (!lock_s) begin
              cnt_q <= StableLoad;
            end else if (cnt_q == '0) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StLocked, StFault: ;
          default: begin
            state_q     <= StFault;
            pll_reset_q <= 1'b1;
            fault_q     <= 1'b1;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.icpsel    = sel_q.icpsel;
  assign bus.lpfres    = sel_q.lpfres;
  assign bus.lpfcap    = sel_q.lpfcap;
  assign bus.mdsel     = sel_q.mdsel;
  assign bus.odsel0    = sel_q.odsel0;
  assign bus.cur_mode  = cur_mode_q;
  assign bus.locked    = locked_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;
  assign bus.req_err   = req_err_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl: table-driven mode requests plus directed
// sequences for power-up, lock glitch, lock timeout/fault and mid-sequence reset.
module tb_pll_dyn_ctrl;

  localparam int unsigned NMODES        = 4;
  localparam int unsigned MODE_W        = 3;
  localparam int unsigned RST_CYCLES    = 16;
  localparam int unsigned SETTLE_CYCLES = 8;
  localparam int unsigned LOCK_TIMEOUT  = 200;
  localparam int unsigned LOCK_STABLE   = 32;
  localparam int unsigned MAX_RETRY     = 3;
  localparam int          LOCK_DLY      = 100;

  // {odsel0, mdsel, lpfcap, lpfres, icpsel}
  localparam logic [24:0] E0 = {7'd10, 7'd20, 2'd1, 3'd2, 6'd3};
  localparam logic [24:0] E1 = {7'd11, 7'd21, 2'd2, 3'd3, 6'd4};
  localparam logic [24:0] E2 = {7'd12, 7'd22, 2'd3, 3'd4, 6'd5};
  localparam logic [24:0] E3 = {7'd13, 7'd23, 2'd0, 3'd5, 6'd6};
  localparam logic [NMODES*25-1:0] TABLE = {E3, E2, E1, E0};

  // Negedge samples from first pll_reset-low sample to locked: model delay,
  // 2-FF sync + 1 reaction cycle, then LOCK_STABLE cycles in STABLE.
  localparam int RelockN = LOCK_DLY - 1 + 3 + LOCK_STABLE;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pll_dyn_ctrl_if #(.MODE_W(MODE_W)) bus ();

  pll_dyn_ctrl #(
    .NMODES        (NMODES),
    .MODE_W        (MODE_W),
    .MODE_TABLE    (TABLE),
    .RST_CYCLES    (RST_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .LOCK_STABLE   (LOCK_STABLE),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // PLL lock model: asserts LOCK_DLY cycles after pll_reset falls.
  int lock_ctr = 0;
  bit lock_en  = 1'b1;
  bit glitch   = 1'b0;
  always @(negedge clk) begin
    if (bus.pll_reset) lock_ctr = 0;
    else if (lock_ctr < LOCK_DLY) lock_ctr++;
    bus.pll_lock = lock_en && !glitch && (lock_ctr >= LOCK_DLY);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] cur_entry();
    return {bus.odsel0, bus.mdsel, bus.lpfcap, bus.lpfres, bus.icpsel};
  endfunction

  // Counts consecutive negedge samples (current one included) with pll_reset == lvl.
  task automatic measure_level(input logic lvl, output int n);
    n = 0;
    while (bus.pll_reset === lvl && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_locked(output int n);
    n = 0;
    while (bus.locked !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Request seen at edge N; returns at the negedge after N.
  task automatic pulse_req(input logic [MODE_W-1:0] m, input bit lock_on);
    @(posedge clk);
    #1;
    lock_en      = lock_on;
    bus.mode_sel = m;
    bus.mode_req = 1'b1;
    @(posedge clk);
    #1;
    bus.mode_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pll_reset"}, bus.pll_reset, 1);
    check({tag, " cur_mode"},  bus.cur_mode,  0);
    check({tag, " selects"},   cur_entry(),   E0);
    check({tag, " locked"},    bus.locked,    0);
    check({tag, " busy"},      bus.busy,      1);
    check({tag, " fault"},     bus.fault,     0);
    check({tag, " req_err"},   bus.req_err,   0);
  endtask

  // Releases reset at a negedge and checks the automatic mode-0 bring-up.
  task automatic release_and_lock(input string tag);
    int n;
    reset = 1'b0;
    measure_level(1'b1, n);
    check({tag, " hold cycles"}, 32'(n), RST_CYCLES);
    check({tag, " busy in wait"}, bus.busy, 1);
    wait_locked(n);
    check({tag, " lock latency"}, 32'(n), RelockN);
    check({tag, " locked"},   bus.locked,   1);
    check({tag, " busy"},     bus.busy,     0);
    check({tag, " selects"},  cur_entry(),  E0);
    check({tag, " cur_mode"}, bus.cur_mode, 0);
  endtask

  typedef struct {
    logic [MODE_W-1:0] sel;
    logic              exp_reset;
    logic              exp_err;
    logic [MODE_W-1:0] exp_cur;
    logic [24:0]       exp_entry;
    logic              exp_locked;
    logic              exp_busy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{3'd2, 1'b1, 1'b0, 3'd2, E2, 1'b0, 1'b1};
    vecs[1] = '{3'd5, 1'b0, 1'b1, 3'd2, E2, 1'b1, 1'b0};
    vecs[2] = '{3'd2, 1'b0, 1'b0, 3'd2, E2, 1'b1, 1'b0};
    vecs[3] = '{3'd3, 1'b1, 1'b0, 3'd3, E3, 1'b0, 1'b1};
    vecs[4] = '{3'd7, 1'b0, 1'b1, 3'd3, E3, 1'b1, 1'b0};
    vecs[5] = '{3'd0, 1'b1, 1'b0, 3'd0, E0, 1'b0, 1'b1};
    vecs[6] = '{3'd1, 1'b1, 1'b0, 3'd1, E1, 1'b0, 1'b1};

    bus.mode_sel = '0;
    bus.mode_req = 1'b0;

    // Power-up
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    release_and_lock("powerup");

    // Table-driven mode requests from LOCKED
    for (int i = 0; i < 7; i++) begin
      pulse_req(vecs[i].sel, 1'b1);
      check($sformatf("v%0d pll_reset", i), bus.pll_reset, vecs[i].exp_reset);
      check($sformatf("v%0d req_err", i),   bus.req_err,   vecs[i].exp_err);
      check($sformatf("v%0d cur_mode", i),  bus.cur_mode,  vecs[i].exp_cur);
      check($sformatf("v%0d selects", i),   cur_entry(),   vecs[i].exp_entry);
      check($sformatf("v%0d locked", i),    bus.locked,    vecs[i].exp_locked);
      check($sformatf("v%0d busy", i),      bus.busy,      vecs[i].exp_busy);
      if (vecs[i].exp_reset) begin
        measure_level(1'b1, n);
        check($sformatf("v%0d hold cycles", i), 32'(n), RST_CYCLES);
        wait_locked(n);
        check($sformatf("v%0d lock latency", i), 32'(n), RelockN);
        check($sformatf("v%0d relock cur_mode", i), bus.cur_mode, vecs[i].exp_cur);
        check($sformatf("v%0d relock selects", i),  cur_entry(),  vecs[i].exp_entry);
      end else begin
        @(negedge clk);
        check($sformatf("v%0d req_err cleared", i), bus.req_err, 0);
        check($sformatf("v%0d still locked", i),    bus.locked,  1);
        check($sformatf("v%0d no pll_reset", i),    bus.pll_reset, 0);
      end
    end

    // One-cycle lock glitch in LOCKED -> one retry, then relock
    @(posedge clk);
    #1 glitch = 1'b1;
    @(posedge clk);
    #1 glitch = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.locked === 1'b1 && n < 20);
    check("glitch locked fall delay", 32'(n), 3);
    check("glitch pll_reset", bus.pll_reset, 1);
    check("glitch busy", bus.busy, 1);
    check("glitch cur_mode", bus.cur_mode, 1);
    measure_level(1'b1, n);
    check("glitch hold cycles", 32'(n), RST_CYCLES);
    wait_locked(n);
    check("glitch lock latency", 32'(n), RelockN);
    check("glitch retry count", 32'(dut.retry_q), 1);
    check("glitch fault", bus.fault, 0);

    // Lock never arrives -> MAX_RETRY attempts -> FAULT
    pulse_req(3'd2, 1'b0);
    for (int a = 0; a < int'(MAX_RETRY); a++) begin
      measure_level(1'b1, n);
      check($sformatf("timeout a%0d hold", a), 32'(n), RST_CYCLES);
      check($sformatf("timeout a%0d fault", a), bus.fault, 0);
      measure_level(1'b0, n);
      check($sformatf("timeout a%0d wait", a), 32'(n), LOCK_TIMEOUT);
    end
    check("fault flag", bus.fault, 1);
    check("fault pll_reset", bus.pll_reset, 1);
    check("fault busy", bus.busy, 0);
    check("fault locked", bus.locked, 0);
    repeat (40) @(negedge clk);
    check("fault sticky", bus.fault, 1);
    check("fault pll_reset sticky", bus.pll_reset, 1);
    pulse_req(3'd0, 1'b1);
    check("unfault fault", bus.fault, 0);
    check("unfault busy", bus.busy, 1);
    check("unfault pll_reset", bus.pll_reset, 1);
    check("unfault cur_mode", bus.cur_mode, 0);
    measure_level(1'b1, n);
    check("unfault hold", 32'(n), RST_CYCLES);
    wait_locked(n);
    check("unfault lock latency", 32'(n), RelockN);

    // Reset while in WAIT_LOCK with mode 3
    pulse_req(3'd3, 1'b0);
    measure_level(1'b1, n);
    check("mid hold", 32'(n), RST_CYCLES);
    repeat (20) @(negedge clk);
    check("mid cur_mode", bus.cur_mode, 3);
    check("mid selects", cur_entry(), E3);
    check("mid pll_reset", bus.pll_reset, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    @(posedge clk);
    #1 lock_en = 1'b1;
    @(negedge clk);
    release_and_lock("midrelease");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
